// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: ID-stage inputs, pipeline controls and EX-stage outputs.
// The master side drives ID fields and stall/flush; the slave side is the register itself.
interface id_ex_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] id_pc4;
   logic [DATA_W-1:0] id_rd1;
   logic [DATA_W-1:0] id_rd2;
   logic [DATA_W-1:0] id_imm;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic [REG_W-1:0]  id_rd;
   logic [8:0]        id_ctrl;
   logic [DATA_W-1:0] ex_pc4;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [8:0]        ex_ctrl;
   logic              ex_valid;
   logic              load_use;

   modport master (
      output stall, flush, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_ctrl,
      input  ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, ex_valid, load_use
   );

   modport slave (
      input  stall, flush, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_ctrl,
      output ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl, ex_valid, load_use
   );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling and bubble insertion.
// Optional bubble counter port bubble_cnt is built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   id_ex_reg_if.slave  bus
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0] bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_BUBBLE = 2'd2
   } act_e;

   logic [DATA_W-1:0] pc4_r;
   logic [DATA_W-1:0] rd1_r;
   logic [DATA_W-1:0] rd2_r;
   logic [DATA_W-1:0] imm_r;
   logic [REG_W-1:0]  rs_r;
   logic [REG_W-1:0]  rt_r;
   logic [REG_W-1:0]  rd_r;
   logic [8:0]        ctrl_r;
   logic              valid_r;
   logic              load_use_s;
   act_e              act_s;

   // Load in EX whose destination (rt) is a source of the instruction now in ID; $zero never hazards
   always_comb begin
      load_use_s = 1'b0;
      if (valid_r && ctrl_r[4] && (rt_r != {REG_W{1'b0}}) &&
          ((rt_r == bus.id_rs) || (rt_r == bus.id_rt))) begin
         load_use_s = 1'b1;
      end else begin
         load_use_s = 1'b0;
      end
   end

   // One action per edge: flush beats stall, stall beats a pending load-use bubble
   always_comb begin
      act_s = ACT_LOAD;
      if (bus.flush) begin
         act_s = ACT_BUBBLE;
      end else if (bus.stall) begin
         act_s = ACT_HOLD;
      end else if (load_use_s) begin
         act_s = ACT_BUBBLE;
      end else begin
         act_s = ACT_LOAD;
      end
   end

   // Pipeline register; a bubble only kills control and valid so stale data writes nothing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc4_r   <= {DATA_W{1'b0}};
         rd1_r   <= {DATA_W{1'b0}};
         rd2_r   <= {DATA_W{1'b0}};
         imm_r   <= {DATA_W{1'b0}};
         rs_r    <= {REG_W{1'b0}};
         rt_r    <= {REG_W{1'b0}};
         rd_r    <= {REG_W{1'b0}};
         ctrl_r  <= 9'h000;
         valid_r <= 1'b0;
      end else begin
         case (act_s)
            ACT_LOAD: begin
               pc4_r   <= bus.id_pc4;
               rd1_r   <= bus.id_rd1;
               rd2_r   <= bus.id_rd2;
               imm_r   <= bus.id_imm;
               rs_r    <= bus.id_rs;
               rt_r    <= bus.id_rt;
               rd_r    <= bus.id_rd;
               ctrl_r  <= bus.id_ctrl;
               valid_r <= 1'b1;
            end
            ACT_BUBBLE: begin
               ctrl_r  <= 9'h000;
               valid_r <= 1'b0;
            end
            ACT_HOLD: begin
               ctrl_r  <= ctrl_r;
               valid_r <= valid_r;
            end
            default: begin
               ctrl_r  <= ctrl_r;
               valid_r <= valid_r;
            end
         endcase
      end
   end

   assign bus.ex_pc4   = pc4_r;
   assign bus.ex_rd1   = rd1_r;
   assign bus.ex_rd2   = rd2_r;
   assign bus.ex_imm   = imm_r;
   assign bus.ex_rs    = rs_r;
   assign bus.ex_rt    = rt_r;
   assign bus.ex_rd    = rd_r;
   assign bus.ex_ctrl  = ctrl_r;
   assign bus.ex_valid = valid_r;
   assign bus.load_use = load_use_s;

`ifdef ID_EX_PERF_EN
   logic [31:0] bubble_cnt_r;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Counts bubble edges, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_r <= 32'd0;
      end else if (act_s == ACT_BUBBLE) begin
         bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end

   assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic against a rule-level model.
// Bubble-counter checks compile only when ID_EX_PERF_EN is defined.
module tb_id_ex_reg;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [8:0]  ctrl;
      logic        valid;
   } st_t;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;
   st_t         m;
   logic [31:0] m_cnt;

   id_ex_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

`ifdef ID_EX_PERF_EN
   logic [31:0] bubble_cnt;
   id_ex_reg #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .bubble_cnt(bubble_cnt)
   );
`else
   id_ex_reg #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic st_t observe();
      return {bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
              bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_ctrl, bus.ex_valid};
   endfunction

   // Hazard rule: a valid load in EX writing a nonzero register that ID reads
   function automatic logic model_lu();
      return m.valid && m.ctrl[4] && (m.rt != 5'd0) &&
             ((m.rt == bus.id_rs) || (m.rt == bus.id_rt));
   endfunction

   task automatic drive_id(input logic [31:0] pc4, input logic [31:0] rd1,
                           input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [8:0] ctrl);
      bus.id_pc4  = pc4;
      bus.id_rd1  = rd1;
      bus.id_rd2  = rd2;
      bus.id_imm  = imm;
      bus.id_rs   = rs;
      bus.id_rt   = rt;
      bus.id_rd   = rd;
      bus.id_ctrl = ctrl;
   endtask

   // Advance one clock edge and move the model by the pipeline rules
   task automatic tick();
      st_t         nx;
      logic [31:0] nc;
      nx = m;
      nc = m_cnt;
      if (bus.flush || (!bus.stall && model_lu())) begin
         nx.ctrl  = 9'h000;
         nx.valid = 1'b0;
         if (m_cnt != 32'hFFFF_FFFF) nc = m_cnt + 32'd1;
      end else if (!bus.stall) begin
         nx = {bus.id_pc4, bus.id_rd1, bus.id_rd2, bus.id_imm,
               bus.id_rs, bus.id_rt, bus.id_rd, bus.id_ctrl, 1'b1};
      end
      @(posedge clk);
      #1;
      m     = nx;
      m_cnt = nc;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive_id(32'hA5A5_A5A5, 32'h1, 32'h2, 32'h3, 5'd7, 5'd7, 5'd7, 9'h1FF);
      m     = '0;
      m_cnt = 32'd0;
      #22;
      checks++;
      if (observe() !== st_t'(0)) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", observe(), st_t'(0));
      end
      checks++;
      if (bus.load_use !== 1'b0) begin
         errors++;
         $display("FAIL reset_load_use: got %b expected 0", bus.load_use);
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (bubble_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %h expected 0", bubble_cnt);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      drive_id(32'h0000_0104, 32'h0000_1234, 32'h0000_0055, 32'hFFFF_FFFC,
               5'd1, 5'd2, 5'd3, 9'h0C3);
      tick();
      checks++;
      if (bus.ex_rd1 !== 32'h0000_1234 || bus.ex_imm !== 32'hFFFF_FFFC ||
          bus.ex_ctrl !== 9'h0C3 || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL load_fields: got rd1=%h imm=%h ctrl=%h valid=%b expected 00001234 fffffffc 0c3 1",
                  bus.ex_rd1, bus.ex_imm, bus.ex_ctrl, bus.ex_valid);
      end
      checks++;
      if (observe() !== m) begin
         errors++;
         $display("FAIL load_state: got %h expected %h", observe(), m);
      end
   endtask

   task automatic test_load_use();
      drive_id(32'h0000_0108, 32'h0000_1000, 32'h0, 32'h0000_0010, 5'd1, 5'd8, 5'd0, 9'h096);
      tick();
      drive_id(32'h0000_010C, 32'h0000_0011, 32'h0000_0022, 32'h0, 5'd8, 5'd9, 5'd10, 9'h182);
      #1;
      checks++;
      if (bus.load_use !== 1'b1) begin
         errors++;
         $display("FAIL lu_raise: got %b expected 1", bus.load_use);
      end
      tick();
      checks++;
      if (bus.ex_ctrl !== 9'h000 || bus.ex_valid !== 1'b0 || bus.ex_rt !== 5'd8) begin
         errors++;
         $display("FAIL lu_bubble: got ctrl=%h valid=%b rt=%0d expected 000 0 8",
                  bus.ex_ctrl, bus.ex_valid, bus.ex_rt);
      end
      checks++;
      if (bus.load_use !== 1'b0) begin
         errors++;
         $display("FAIL lu_clear: got %b expected 0", bus.load_use);
      end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 9'h182 || bus.ex_rs !== 5'd8 ||
          observe() !== m) begin
         errors++;
         $display("FAIL lu_reload: got %h expected %h", observe(), m);
      end
   endtask

   task automatic test_reg_zero();
      drive_id(32'h0000_0200, 32'h0, 32'h0, 32'h4, 5'd0, 5'd0, 5'd0, 9'h096);
      tick();
      drive_id(32'h0000_0204, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd4, 9'h182);
      #1;
      checks++;
      if (bus.load_use !== 1'b0) begin
         errors++;
         $display("FAIL zero_lu: got %b expected 0", bus.load_use);
      end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 9'h182 || bus.ex_rd !== 5'd4) begin
         errors++;
         $display("FAIL zero_load: got %h expected %h", observe(), m);
      end
   endtask

   task automatic test_stall_hazard();
      st_t snap;
      drive_id(32'h0000_0300, 32'h7, 32'h0, 32'h8, 5'd2, 5'd8, 5'd0, 9'h096);
      tick();
      snap = m;
      drive_id(32'h0000_0304, 32'h1, 32'h2, 32'h0, 5'd3, 5'd8, 5'd5, 9'h182);
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (bus.load_use !== 1'b1) begin
            errors++;
            $display("FAIL stall_lu_pending: got %b expected 1", bus.load_use);
         end
         tick();
         checks++;
         if (observe() !== snap) begin
            errors++;
            $display("FAIL stall_lu_hold: got %h expected %h", observe(), snap);
         end
      end
      bus.stall = 1'b0;
      tick();
      checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 9'h000) begin
         errors++;
         $display("FAIL stall_lu_bubble: got %h expected %h", observe(), m);
      end
      tick();
      checks++;
      if (observe() !== m || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_lu_after: got %h expected %h", observe(), m);
      end
   endtask

   task automatic test_priority();
      st_t snap;
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      tick();
      checks++;
      if (bus.ex_ctrl !== 9'h000 || bus.ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_over_stall: got ctrl=%h valid=%b expected 000 0",
                  bus.ex_ctrl, bus.ex_valid);
      end
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      drive_id(32'h0000_0400, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 5'd11, 5'd12, 5'd13, 9'h1A3);
      tick();
      snap = m;
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 9'($urandom_range(0, 511)));
         tick();
         checks++;
         if (observe() !== snap) begin
            errors++;
            $display("FAIL stall_hold_%0d: got %h expected %h", i, observe(), snap);
         end
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bus.flush = ($urandom_range(0, 9) == 0);
         bus.stall = ($urandom_range(0, 4) == 0);
         drive_id($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 9'($urandom_range(0, 511)));
         #1;
         checks++;
         if (bus.load_use !== model_lu()) begin
            errors++;
            $display("FAIL rand_lu_%0d: got %b expected %b", i, bus.load_use, model_lu());
         end
         tick();
         checks++;
         if (observe() !== m) begin
            errors++;
            $display("FAIL rand_state_%0d: got %h expected %h", i, observe(), m);
         end
`ifdef ID_EX_PERF_EN
         checks++;
         if (bubble_cnt !== m_cnt) begin
            errors++;
            $display("FAIL rand_cnt_%0d: got %h expected %h", i, bubble_cnt, m_cnt);
         end
`endif
      end
      bus.flush = 1'b0;
      bus.stall = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drive_id(32'h0000_0500, 32'h9, 32'hA, 32'hB, 5'd6, 5'd5, 5'd4, 9'h1FF);
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 9'h1FF) begin
         errors++;
         $display("FAIL async_setup: got ctrl=%h valid=%b expected 1ff 1", bus.ex_ctrl, bus.ex_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (observe() !== st_t'(0) || bus.load_use !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got %h lu=%b expected %h lu=0", observe(), bus.load_use, st_t'(0));
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (bubble_cnt !== 32'd0) begin
         errors++;
         $display("FAIL async_reset_cnt: got %h expected 0", bubble_cnt);
      end
`endif
      m     = '0;
      m_cnt = 32'd0;
      #2;
      rst_n = 1'b1;
      drive_id(32'h0000_0600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 9'h0C3);
      tick();
      checks++;
      if (observe() !== m || bus.ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_reset_load: got %h expected %h", observe(), m);
      end
   endtask

`ifdef ID_EX_PERF_EN
   task automatic test_counter();
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m     = '0;
      m_cnt = 32'd0;
      drive_id(32'h0000_0700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 9'h0C3);
      bus.flush = 1'b1;
      tick();
      tick();
      bus.flush = 1'b0;
      drive_id(32'h0000_0704, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0, 9'h096);
      tick();
      drive_id(32'h0000_0708, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9, 5'd10, 9'h182);
      tick();
      bus.stall = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.stall = 1'b0;
      checks++;
      if (bubble_cnt !== 32'd3 || m_cnt !== 32'd3) begin
         errors++;
         $display("FAIL cnt_three: got %0d expected 3", bubble_cnt);
      end
      force dut.bubble_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.bubble_cnt_r;
      m_cnt = 32'hFFFF_FFFF;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++;
      if (bubble_cnt !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL cnt_saturate: got %h expected ffffffff", bubble_cnt);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load();
      test_load_use();
      test_reg_zero();
      test_stall_hazard();
      test_priority();
      test_random();
      test_async_reset();
`ifdef ID_EX_PERF_EN
      test_counter();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
